l1_ahb_mtx_in_stg: RTL

Master-side input stage of the L1 AHB bus matrix, one instance per master port. It sits between a master and the matrix decoder/output arbiters. When the arbiter for the target slave has not granted this port, it captures and holds the master's address phase and stalls the master. It replays the held transfer once granted, and breaks interrupted bursts into legal INCR sequences.

---
 rtl/l1_ahb_mtx_in_stg.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/l1_ahb_mtx_in_stg.sv
// Master-side input stage of the L1 AHB matrix: holds an ungranted address phase,
// stalls the master, and replays it as a legal INCR sequence once the arbiter grants.
module l1_ahb_mtx_in_stg #(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    input  logic              active_decoder,
    input  logic              readyout_decoder,
    input  logic [1:0]        resp_decoder,
    output logic              HSELM,
    output logic [ADDR_W-1:0] HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [3:0]        HPROTM,
    output logic              HMASTLOCKM,
    output logic              HREADYOUTS,
    output logic [1:0]        HRESPS,
    output logic              trans_pend
);

    localparam logic [1:0] TRN_IDLE   = 2'b00;
    localparam logic [1:0] TRN_NONSEQ = 2'b10;
    localparam logic [1:0] TRN_SEQ    = 2'b11;
    localparam logic [2:0] BRST_INCR  = 3'b001;
    localparam logic [1:0] RSP_OKAY   = 2'b00;

    logic              pend_q, pend_d;
    logic              brk_q, brk_d;
    logic              hsel_q;
    logic [ADDR_W-1:0] haddr_q;
    logic [1:0]        htrans_q;
    logic              hwrite_q;
    logic [2:0]        hsize_q;
    logic [2:0]        hburst_q;
    logic [3:0]        hprot_q;
    logic              hlock_q;

    logic sample;
    logic set_pend;
    logic clr_pend;
    logic brk_clr;
    logic brk_ovr;

    assign sample   = HSELS & HTRANSS[1] & HREADYS;
    assign set_pend = sample & ~active_decoder;
    assign clr_pend = pend_q & active_decoder & readyout_decoder;
    // A NONSEQ or IDLE accepted on the master bus ends the broken burst.
    assign brk_clr  = ~pend_q & HREADYS & ~HTRANSS[0];

    always_comb begin
        pend_d = pend_q;
        if (set_pend) begin
            pend_d = 1'b1;
        end else if (clr_pend) begin
            pend_d = 1'b0;
        end
    end

    always_comb begin
        brk_d = brk_q;
        if (set_pend) begin
            brk_d = (HTRANSS == TRN_SEQ);
        end else if (brk_clr) begin
            brk_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_q <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            brk_q  <= brk_d;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hsel_q   <= 1'b0;
            haddr_q  <= '0;
            htrans_q <= TRN_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'b000;
            hburst_q <= 3'b000;
            hprot_q  <= 4'b0000;
            hlock_q  <= 1'b0;
        end else if (set_pend) begin
            hsel_q   <= HSELS;
            haddr_q  <= HADDRS;
            htrans_q <= HTRANSS;
            hwrite_q <= HWRITES;
            hsize_q  <= HSIZES;
            hburst_q <= HBURSTS;
            hprot_q  <= HPROTS;
            hlock_q  <= HMASTLOCKS;
        end
    end

    // Burst rewrite covers the replayed beat and the continuing beats of the
    // broken burst; a fresh NONSEQ from the master goes through untouched.
    assign brk_ovr = brk_q & (pend_q | HTRANSS[0]);

    always_comb begin
        if (pend_q) begin
            HSELM      = hsel_q;
            HADDRM     = haddr_q;
            HTRANSM    = brk_q ? TRN_NONSEQ : htrans_q;
            HWRITEM    = hwrite_q;
            HSIZEM     = hsize_q;
            HBURSTM    = brk_ovr ? BRST_INCR : hburst_q;
            HPROTM     = hprot_q;
            HMASTLOCKM = hlock_q;
            HREADYOUTS = 1'b0;
            HRESPS     = RSP_OKAY;
        end else begin
            HSELM      = HSELS;
            HADDRM     = HADDRS;
            HTRANSM    = HTRANSS;
            HWRITEM    = HWRITES;
            HSIZEM     = HSIZES;
            HBURSTM    = brk_ovr ? BRST_INCR : HBURSTS;
            HPROTM     = HPROTS;
            HMASTLOCKM = HMASTLOCKS;
            HREADYOUTS = readyout_decoder;
            HRESPS     = resp_decoder;
        end
    end

    assign trans_pend = pend_q;

endmodule
